ysyx_22041461_id_ex: RTL

YSYX_22041461_ID_EX -- requirements
Module: ysyx_22041461_id_ex

---
 rtl/ysyx_22041461_id_ex_pkg.sv | 32 +++
 rtl/ysyx_22041461_payload_reg.sv | 24 ++
 rtl/ysyx_22041461_id_ex.sv | 135 +++++++++++++
 3 files changed

// File: rtl/ysyx_22041461_id_ex_pkg.sv
// Shared types for the ID/EX skid buffer: the payload record, the buffer state and ALU opcodes.
// The optional stall counter in the top is enabled by YSYX_22041461_ID_EX_PERF_EN.
package ysyx_22041461_id_ex_pkg;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] src1;
    logic [63:0] src2;
    logic [4:0]  ctrl_ALU;
    logic [4:0]  rd;
    logic        wen;
  } payload_t;

  localparam int PAYLOAD_W = $bits(payload_t);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // ALU opcodes carried untouched through ctrl_ALU
  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_XOR = 5'b00100;
  localparam logic [4:0] ALU_SLL = 5'b01010;
  localparam logic [4:0] ALU_SRL = 5'b01011;
  localparam logic [4:0] ALU_SRA = 5'b01100;

endpackage

// File: rtl/ysyx_22041461_payload_reg.sv
// One 203-bit pipeline payload register with async clear and load enable.
module ysyx_22041461_payload_reg
  import ysyx_22041461_id_ex_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     load,
  input  payload_t d,
  output payload_t q
);

  payload_t q_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg <= '0;
    end else if (load) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/ysyx_22041461_id_ex.sv
// ID/EX pipeline register built as a 2-entry skid buffer (main drives outputs, skid absorbs back-pressure).
// Defining YSYX_22041461_ID_EX_PERF_EN adds a 32-bit stall_cnt output.
module ysyx_22041461_id_ex
  import ysyx_22041461_id_ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_pc,
  input  logic [63:0] in_src1,
  input  logic [63:0] in_src2,
  input  logic [4:0]  in_ctrl_ALU,
  input  logic [4:0]  in_rd,
  input  logic        in_wen,
  input  logic        flush,
`ifdef YSYX_22041461_ID_EX_PERF_EN
  output logic [31:0] stall_cnt,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [63:0] out_src1,
  output logic [63:0] out_src2,
  output logic [4:0]  out_ctrl_ALU,
  output logic [4:0]  out_rd,
  output logic        out_wen
);

  localparam int MAIN = 0;
  localparam int SKID = 1;

  state_t   state_reg, state_next;
  logic     accept, consume;
  logic     main_load, skid_load, main_from_skid;
  payload_t in_payload;
  payload_t entry_d    [2];
  logic     entry_load [2];
  payload_t entry_q    [2];

  assign in_payload = '{pc: in_pc, src1: in_src1, src2: in_src2,
                        ctrl_ALU: in_ctrl_ALU, rd: in_rd, wen: in_wen};

  // Handshake flags come from registered state only; out_ready never reaches in_ready.
  assign in_ready  = (state_reg != FULL);
  assign out_valid = (state_reg != EMPTY);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      // Kill wins over any handshake; stale register contents are masked by out_valid.
      state_next = EMPTY;
    end else begin
      unique case (state_reg)
        EMPTY: begin
          if (accept) begin
            main_load  = 1'b1;
            state_next = ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_load = 1'b1;
          end else if (accept) begin
            skid_load  = 1'b1;
            state_next = FULL;
          end else if (consume) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (consume) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            state_next     = ONE;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  assign entry_d[MAIN]    = main_from_skid ? entry_q[SKID] : in_payload;
  assign entry_load[MAIN] = main_load;
  assign entry_d[SKID]    = in_payload;
  assign entry_load[SKID] = skid_load;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      ysyx_22041461_payload_reg u_reg (
        .clk  (clk),
        .rst  (rst),
        .load (entry_load[gi]),
        .d    (entry_d[gi]),
        .q    (entry_q[gi])
      );
    end
  endgenerate

  assign out_pc       = entry_q[MAIN].pc;
  assign out_src1     = entry_q[MAIN].src1;
  assign out_src2     = entry_q[MAIN].src2;
  assign out_ctrl_ALU = entry_q[MAIN].ctrl_ALU;
  assign out_rd       = entry_q[MAIN].rd;
  assign out_wen      = entry_q[MAIN].wen;

`ifdef YSYX_22041461_ID_EX_PERF_EN
  logic [31:0] stall_cnt_reg;

  // Counts edges where execute holds off a valid payload; flush leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (out_valid && !out_ready) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule
